apb_slave_mem: RTL

- APB responder (completer) sitting at the far end of the AHB-to-APB bridge: one instance per Pselx bit.
- Decodes a single APB peripheral select and serves reads/writes from an internal word-addressed register file.
- Inserts a parameterised number of wait states via Pready.
- Flags out-of-range or misaligned accesses with Pslverr.

---
 rtl/apb_slave_mem.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// APB completer backed by a small word-addressed register file.
// Decodes one peripheral window, inserts WAIT_STATES wait cycles, flags bad accesses via Pslverr.
module apb_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned AW          = 4,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          write_q, write_d;
  logic          err_q, err_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   prdata_q, prdata_d;
  logic          pready_q, pready_d;
  logic          pslverr_q, pslverr_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];

  logic          setup_hit;
  logic          setup_aligned;
  logic          setup_err;
  logic [AW-1:0] setup_idx;

  always_comb begin
    setup_hit     = (Paddr[31:AW+2] == BASE_ADDR[31:AW+2]);
    setup_aligned = (Paddr[1:0] == 2'b00);
    setup_err     = !setup_hit || !setup_aligned;
    setup_idx     = Paddr[AW+1:2];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    mem_d     = mem_q;

    case (state_q)
      IDLE: begin
        if (Psel && !Penable) begin
          state_d  = ACCESS;
          idx_d    = setup_idx;
          write_d  = Pwrite;
          err_d    = setup_err;
          wdata_d  = Pwdata;
          // Read data is captured once here and held through any wait states.
          prdata_d = (!Pwrite && !setup_err) ? mem_q[setup_idx] : 32'h0;
          if (WS == 3'd0) begin
            cnt_d     = 3'd0;
            pready_d  = 1'b1;
            pslverr_d = setup_err;
          end else begin
            cnt_d     = WS;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (!(Psel && Penable)) begin
          state_d   = IDLE;
          cnt_d     = 3'd0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = 32'h0;
        end else if (pready_q) begin
          if (write_q && !err_q) begin
            mem_d[idx_q] = wdata_q;
          end
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = 32'h0;
        end else begin
          cnt_d = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
          if (cnt_q <= 3'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= 32'h0;
      prdata_q  <= 32'h0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      mem_q     <= '{default: 32'h0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      mem_q     <= mem_d;
    end
  end

  // Completion is never signalled to a master that has already deselected us.
  assign Prdata  = prdata_q;
  assign Pready  = pready_q & Psel;
  assign Pslverr = pslverr_q & Psel;

endmodule
